// File: rtl/uart_rx_pkg.sv
// Shared UART constants and reload helpers used by uart_rx and uart_tx.
package uart_rx_pkg;

  // Clocks per bit are prescale * 2**OVERSAMPLE_SHIFT (8x oversampling).
  localparam int OVERSAMPLE_SHIFT = 3;
  // The first wait after a falling edge is half a bit: prescale * 2**HALF_BIT_SHIFT.
  localparam int HALF_BIT_SHIFT   = 2;
  // Counter width wide enough for 65535 << 3 without truncation.
  localparam int PRESCALE_CNT_W   = 19;

  // Countdown reload for one full bit period.
  function automatic logic [PRESCALE_CNT_W-1:0] bit_reload(input logic [15:0] prescale);
    logic [PRESCALE_CNT_W-1:0] wide;
    wide = {3'b000, prescale};
    return (wide << OVERSAMPLE_SHIFT) - 19'd1;
  endfunction

  // Countdown reload from the start edge to the middle of the start bit.
  function automatic logic [PRESCALE_CNT_W-1:0] half_reload(input logic [15:0] prescale);
    logic [PRESCALE_CNT_W-1:0] wide;
    wide = {3'b000, prescale};
    return (wide << HALF_BIT_SHIFT) - 19'd2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) presenting received words on an
// AXI4-Stream master port. Bit timing comes from a run-time prescale
// with 8x oversampling; each bit is sampled once near its centre.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] output_axi_tdata,
  output logic                  output_axi_tvalid,
  input  logic                  output_axi_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  // bit_cnt value while waiting for the start-bit centre.
  localparam logic [3:0] START_CNT = 4'(DATA_WIDTH + 2);

  logic                      rxd_meta;
  logic                      rxd_reg;
  logic [PRESCALE_CNT_W-1:0] prescale_reg;
  logic [3:0]                bit_cnt;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic [DATA_WIDTH-1:0]     data_shift;
  logic                      accept;

  // Output handshake: a word transfers on any clk edge where
  // output_axi_tvalid && output_axi_tready; tvalid then drops on that edge
  // unless a new word lands in the same cycle. tdata is held while tvalid
  // is high, except that an overrun replaces the pending word.
  assign accept = output_axi_tvalid && output_axi_tready;

  // Next data register value: shift right, new bit enters at the MSB.
  always_comb begin
    data_shift                 = data_reg >> 1;
    data_shift[DATA_WIDTH-1]   = rxd_reg;
  end

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_reg  <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_reg  <= rxd_meta;
    end
  end

  // Bit-timing countdown, frame sequencing and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_reg      <= '0;
      bit_cnt           <= '0;
      data_reg          <= '0;
      output_axi_tdata  <= '0;
      output_axi_tvalid <= 1'b0;
      busy              <= 1'b0;
      overrun_error     <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;

      if (accept) begin
        output_axi_tvalid <= 1'b0;
      end

      if (prescale_reg != '0) begin
        // Waiting for the next sample point.
        prescale_reg <= prescale_reg - 19'd1;
      end else if (bit_cnt != 4'd0) begin
        if (bit_cnt == START_CNT) begin
          // Mid start bit: confirm it, otherwise treat the edge as a glitch.
          if (!rxd_reg) begin
            bit_cnt      <= bit_cnt - 4'd1;
            prescale_reg <= bit_reload(prescale);
          end else begin
            bit_cnt <= 4'd0;
            busy    <= 1'b0;
          end
        end else if (bit_cnt > 4'd1) begin
          // Mid data bit.
          data_reg     <= data_shift;
          bit_cnt      <= bit_cnt - 4'd1;
          prescale_reg <= bit_reload(prescale);
        end else begin
          // Mid stop bit: publish the word or flag a framing error.
          bit_cnt <= 4'd0;
          busy    <= 1'b0;
          if (rxd_reg) begin
            output_axi_tdata  <= data_reg;
            output_axi_tvalid <= 1'b1;
            overrun_error     <= output_axi_tvalid && !output_axi_tready;
          end else begin
            frame_error <= 1'b1;
          end
        end
      end else begin
        // Idle: arm on a low line level (also re-triggers on a held break).
        busy <= 1'b0;
        if (!rxd_reg) begin
          prescale_reg <= half_reload(prescale);
          bit_cnt      <= START_CNT;
          busy         <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit,
// expected words are queued when a frame is sent and compared when the
// stream port hands them over.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        rxd = 1'b1;
  logic        busy;
  logic        ovr;
  logic        fe;
  logic [15:0] prescale = 16'd1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int busy_cycles = 0;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .output_axi_tdata  (tdata),
    .output_axi_tvalid (tvalid),
    .output_axi_tready (tready),
    .rxd               (rxd),
    .busy              (busy),
    .overrun_error     (ovr),
    .frame_error       (fe),
    .prescale          (prescale)
  );

  // Clock
  always #5 clk = ~clk;

  // Output monitor: collects accepted words and counts pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (tvalid && tready) got_q.push_back(tdata);
    if (ovr) ovr_cnt++;
    if (fe) fe_cnt++;
    if (busy) busy_cycles++;
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    if (stop_ok) begin
      drive_bit(1'b1, bc);
    end else begin
      drive_bit(1'b0, (bc * 3) / 4);
      drive_bit(1'b1, bc - (bc * 3) / 4);
    end
  endtask

  task automatic wait_got(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %02h expected 00", tdata); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", fe); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single_byte();
    bit ok;
    logic [7:0] got, exp;
    int ovr0, fe0, busy0;
    prescale = 16'd1;
    tready = 1'b1;
    ovr0 = ovr_cnt; fe0 = fe_cnt; busy0 = busy_cycles;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 8);
    wait_got(50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_word: got no word expected 55");
    end else begin
      got = got_q.pop_front(); exp = exp_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL single_word: got %02h expected %02h", got, exp); end
    end
    idle(10);
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    checks++; if (ovr_cnt != ovr0) begin errors++; $display("FAIL single_overrun: got %0d pulses expected 0", ovr_cnt - ovr0); end
    checks++;
    if ((busy_cycles - busy0) < 70 || (busy_cycles - busy0) > 80) begin
      errors++; $display("FAIL single_busy_len: got %0d cycles expected 70..80", busy_cycles - busy0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] got, exp;
    int ovr0;
    prescale = 16'd1;
    tready = 1'b0;
    ovr0 = ovr_cnt;
    // The first word is overwritten before the sink takes it.
    send_frame(8'hA5, 1'b1, 8);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 8);
    idle(4);
    checks++; if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ovr_cnt - ovr0); end
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL b2b_tvalid: got %b expected 1", tvalid); end
    checks++; if (tdata !== 8'h3C) begin errors++; $display("FAIL b2b_tdata: got %02h expected 3c", tdata); end
    tready = 1'b1;
    wait_got(20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_word: got no word expected 3c");
    end else begin
      got = got_q.pop_front(); exp = exp_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL b2b_word: got %02h expected %02h", got, exp); end
    end
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL b2b_tvalid_clear: got %b expected 0", tvalid); end
    @(posedge clk); #1;
    idle(10);
  endtask

  task automatic test_frame_error();
    bit ok;
    logic [7:0] got, exp;
    int fe0, n0;
    prescale = 16'd1;
    tready = 1'b1;
    fe0 = fe_cnt; n0 = got_q.size();
    send_frame(8'hFF, 1'b0, 8);
    idle(40);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL fe_tvalid: got %b expected 0", tvalid); end
    checks++; if (got_q.size() != n0) begin errors++; $display("FAIL fe_no_word: got %0d words expected %0d", got_q.size(), n0); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 8);
    wait_got(50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fe_next_word: got no word expected 12");
    end else begin
      got = got_q.pop_front(); exp = exp_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL fe_next_word: got %02h expected %02h", got, exp); end
    end
    idle(10);
  endtask

  task automatic test_glitch();
    int ovr0, fe0, busy0, n0;
    prescale = 16'd4;
    ovr0 = ovr_cnt; fe0 = fe_cnt; busy0 = busy_cycles; n0 = got_q.size();
    drive_bit(1'b0, 2);
    idle(40);
    checks++; if (busy_cycles == busy0) begin errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles expected >0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
    checks++; if (got_q.size() != n0 || tvalid !== 1'b0) begin errors++; $display("FAIL glitch_no_word: got %0d words tvalid %b expected 0 and 0", got_q.size() - n0, tvalid); end
    checks++; if (ovr_cnt != ovr0 || fe_cnt != fe0) begin errors++; $display("FAIL glitch_errors: got ovr %0d fe %0d expected 0 0", ovr_cnt - ovr0, fe_cnt - fe0); end
  endtask

  task automatic test_baud_tolerance();
    bit ok;
    logic [7:0] got, exp;
    int bc[2];
    bc[0] = 33;
    bc[1] = 31;
    prescale = 16'd4;
    tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, bc[k]);
      wait_got(100, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL baud_%0d: got no word expected 81", bc[k]);
      end else begin
        got = got_q.pop_front(); exp = exp_q.pop_front();
        if (got !== exp) begin errors++; $display("FAIL baud_%0d: got %02h expected %02h", bc[k], got, exp); end
      end
      idle(20);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] got, exp;
    prescale = 16'd1;
    tready = 1'b1;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (tdata !== 8'h00 || tvalid !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0 || fe !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got tdata %02h tvalid %b busy %b ovr %b fe %b expected 00 0 0 0 0", tdata, tvalid, busy, ovr, fe);
    end
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 8);
    wait_got(50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_next_word: got no word expected 7e");
    end else begin
      got = got_q.pop_front(); exp = exp_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL rst_next_word: got %02h expected %02h", got, exp); end
    end
    idle(10);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_baud_tolerance();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL leftovers: got %0d expected and %0d received words left over, expected 0 0", exp_q.size(), got_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

AXI4-Stream UART receiver. It deserializes asynchronous serial data on `rxd` (8N1 framing: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit) into words on an AXI4-Stream master port. The bit rate is set at run time by `prescale` with 8x oversampling. It is the receive-side counterpart of `uart_tx` and sits between the board UART pin and the fabric stream logic.

## Interface

Parameters:
- DATA_WIDTH, 8, data bits per frame (1-8).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- output_axi_tdata  output  DATA_WIDTH  received word
- output_axi_tvalid  output  1  word valid
- output_axi_tready  input  1  sink ready
- rxd  input  1  serial input, idle high, asynchronous to clk
- busy  output  1  high while a frame is being received
- overrun_error  output  1  one-cycle pulse: a new word arrived while the previous word was still pending
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- prescale  input  16  clocks per bit = prescale*8; legal range 1..65535

## Operation

- `rxd` passes through a 2-flop synchronizer (`rxd_reg`, reset 1). All decisions use the synchronized value.
- Internal state: `prescale_reg` (19 bits), `bit_cnt` (4 bits), `data_reg` (DATA_WIDTH bits). Idle is `bit_cnt==0 && prescale_reg==0`.
- Each cycle with `prescale_reg>0`: decrement only; no sampling.
- **Idle:** `busy=0`. If `rxd_reg==0`, load `prescale_reg=(prescale<<2)-2` (half bit), `bit_cnt=DATA_WIDTH+2`, `busy=1`.
- **Start check** (`bit_cnt==DATA_WIDTH+2`, `prescale_reg==0`):
  - If `rxd_reg==0`: `bit_cnt--` and `prescale_reg=(prescale<<3)-1`.
  - Otherwise it is a glitch: `bit_cnt=0`, return to idle, no error flagged.
- **Data** (`bit_cnt` from DATA_WIDTH+1 down to 2, at expiry): `data_reg={rxd_reg, data_reg[DATA_WIDTH-1:1]}`, `bit_cnt--`, reload `(prescale<<3)-1`.
- **Stop** (`bit_cnt==1`, at expiry): `bit_cnt=0`, `busy=0`.
  - If `rxd_reg==1`: `output_axi_tdata=data_reg`, `output_axi_tvalid=1`. If tvalid was already high and not accepted this cycle, pulse `overrun_error`; the new word overwrites the old one.
  - If `rxd_reg==0`: pulse `frame_error` and discard the word. tdata and tvalid are unchanged.
- **Re-arming after stop:** the block returns to idle at mid-stop-bit. A new start is detected only on `rxd_reg==0`, so a stop bit that stays low (break) re-triggers detection.
- **Handshake:** the word is accepted when `output_axi_tvalid && output_axi_tready`; tvalid clears on the following edge. tdata is stable while tvalid is high, except on overrun.
- **Prescale sampling:** `prescale` is sampled at every reload. Changes mid-frame take effect at the next bit.
- **Arithmetic:** `prescale<<3` is computed at 19 bits with no truncation. `prescale=0` is illegal; behaviour is undefined and is not tested.

## Timing

- Reset values: `output_axi_tdata=0`, `output_axi_tvalid=0`, `busy=0`, `overrun_error=0`, `frame_error=0`, `rxd_reg=1`, all counters 0.
- Synchronizer latency: 2 cycles from a `rxd` change to `rxd_reg`.
- `busy` rises 3 cycles after the falling edge of `rxd`.
- Start sample lands 4*prescale cycles after `busy` rises. Data bit k is sampled 8*prescale*(k+1) after the start sample.
- `output_axi_tvalid` rises on the cycle after the stop-bit sample. For prescale=1 and DATA_WIDTH=8 this is about 78 cycles after the `rxd` falling edge.
- Error pulses are exactly 1 cycle wide and coincide with the stop-sample update.
- Acceptance and a new word in the same cycle: tvalid stays 1, tdata takes the new word, and there is no overrun.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost and no pulses are produced.

## Structure

- Single module with no sub-modules. The synchronizer is inline.
- No shared package is needed. If the team package exists, the oversample ratio (8) and the half-bit shift (2) belong there as constants shared with `uart_tx`.

## Test plan

- **Single byte:** prescale=1, drive frame 0x55 at 8 clk/bit → one tvalid with tdata=0x55, both errors 0, busy high for the frame and low after.
- **Back-to-back, stalled sink:** send 0xA5 then 0x3C back-to-back with tready held low → after the second stop bit, `overrun_error` pulses once and tdata=0x3C; assert tready → tvalid clears.
- **Frame error:** send 0xFF with the stop bit forced low → `frame_error` pulses once, tvalid stays 0. A following valid frame 0x12 is received correctly.
- **Glitch rejection:** a 2-cycle low pulse on `rxd` (prescale=4) → busy rises, then returns to idle at the start check with no output and no errors.
- **Baud tolerance:** prescale=4 with the bit period skewed ±3% across the frame for 0x81 → correct tdata=0x81.
- **Async reset mid-frame:** assert rst at data bit 3 → all outputs go to reset values immediately. After release, the next frame 0x7E is received correctly.
